// File: rtl/fetch_pc_sequencer_if.sv
// Fetch PC sequencer bus: redirect, backpressure and predecode inputs,
// IMEM address, valid, squash, epoch, branch fallback and stall count outputs.
interface fetch_pc_sequencer_if #(
  parameter int EPOCH_W = 3,
  parameter int CNT_W   = 16
);
  logic [63:0]        in_entry_pc;
  logic               in_rob_mispredict;
  logic [63:0]        in_rob_new_PC;
  logic               in_d_stall;
  logic               in_f_is_bcond;
  logic               in_f_is_uncond;
  logic               in_f_is_halt;
  logic [63:0]        in_f_imm;
  logic [63:0]        out_imem_addr;
  logic               out_f_valid;
  logic               out_squash;
  logic [EPOCH_W-1:0] out_epoch;
  logic [63:0]        out_branch_PC;
  logic [CNT_W-1:0]   out_stall_cnt;

  modport master (
    output in_entry_pc, in_rob_mispredict, in_rob_new_PC,
    output in_d_stall, in_f_is_bcond, in_f_is_uncond,
    output in_f_is_halt, in_f_imm,
    input  out_imem_addr, out_f_valid, out_squash,
    input  out_epoch, out_branch_PC, out_stall_cnt
  );

  modport slave (
    input  in_entry_pc, in_rob_mispredict, in_rob_new_PC,
    input  in_d_stall, in_f_is_bcond, in_f_is_uncond,
    input  in_f_is_halt, in_f_imm,
    output out_imem_addr, out_f_valid, out_squash,
    output out_epoch, out_branch_PC, out_stall_cnt
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC register and next-PC arbitration: redirect > halt > stall >
// predicted branch > PC+4. Ports: in_clk, in_rst (sync, high), bus (slave).
module fetch_pc_sequencer #(
  parameter int SQUASH_CYCLES = 2,
  parameter int EPOCH_W       = 3,
  parameter int CNT_W         = 16
) (
  input logic                  in_clk,
  input logic                  in_rst,
  fetch_pc_sequencer_if.slave  bus
);

  localparam int SQ_W =
    (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    SQUASH,
    HALT
  } state_t;

  state_t             state_q, state_n;
  logic [63:0]        pc_q, pc_n;
  logic [SQ_W-1:0]    sq_q, sq_n;
  logic [EPOCH_W-1:0] epoch_q, epoch_n;
  logic [63:0]        bpc_q, bpc_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               squash_q;
  logic               valid;
  logic [63:0]        pc_seq;
  logic [63:0]        pc_tgt;
  logic               unused_lo;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_lo = ^bus.in_rob_new_PC[1:0];

  assign pc_seq = pc_q + 64'd4;
  assign pc_tgt = pc_q + bus.in_f_imm;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    sq_n    = sq_q;
    epoch_n = epoch_q;
    bpc_n   = bpc_q;
    cnt_n   = cnt_q;
    valid   = 1'b0;
    if (bus.in_rob_mispredict) begin
      pc_n    = {bus.in_rob_new_PC[63:2], 2'b00};
      epoch_n = epoch_q + EPOCH_W'(1);
      state_n = SQUASH;
      sq_n    = SQ_W'(SQUASH_CYCLES - 1);
    end else begin
      unique case (state_q)
        BOOT: state_n = RUN;
        SQUASH: begin
          if (sq_q == '0) state_n = RUN;
          else sq_n = sq_q - SQ_W'(1);
        end
        HALT: state_n = HALT;
        RUN: begin
          if (bus.in_d_stall) begin
            if (!(&cnt_q)) cnt_n = cnt_q + CNT_W'(1);
          end else begin
            valid = 1'b1;
            if (bus.in_f_is_halt) begin
              state_n = HALT;
            end else if (bus.in_f_is_uncond) begin
              pc_n = pc_tgt;
            end else if (bus.in_f_is_bcond) begin
              pc_n  = pc_seq;
              bpc_n = pc_tgt;
            end else begin
              pc_n = pc_seq;
            end
          end
        end
        default: state_n = BOOT;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= BOOT;
      pc_q     <= bus.in_entry_pc;
      sq_q     <= '0;
      epoch_q  <= '0;
      bpc_q    <= '0;
      cnt_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      sq_q     <= sq_n;
      epoch_q  <= epoch_n;
      bpc_q    <= bpc_n;
      cnt_q    <= cnt_n;
      squash_q <= (state_n == SQUASH);
    end
  end

  assign bus.out_imem_addr = pc_q;
  assign bus.out_f_valid   = valid;
  assign bus.out_squash    = squash_q;
  assign bus.out_epoch     = epoch_q;
  assign bus.out_branch_PC = bpc_q;
  assign bus.out_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vectors, cycle model
// compared every cycle, plus literal pins on key points.
module tb_fetch_pc_sequencer;

  localparam int SQ = 2;
  localparam int EW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  fetch_pc_sequencer_if #(.EPOCH_W(EW), .CNT_W(CW)) bus ();

  fetch_pc_sequencer #(
    .SQUASH_CYCLES(SQ), .EPOCH_W(EW), .CNT_W(CW)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: plain counters and flags, not a state machine encoding.
  logic [63:0] m_pc;
  logic [63:0] m_bpc;
  bit          m_boot;
  bit          m_halted;
  int          m_sq_left;
  int          m_epoch;
  int          m_cnt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_valid();
    return !m_boot && !m_halted && m_sq_left == 0 &&
           !bus.in_d_stall && !bus.in_rob_mispredict;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = bus.in_entry_pc; m_bpc = 0; m_boot = 1; m_halted = 0;
      m_sq_left = 0; m_epoch = 0; m_cnt = 0;
    end else if (bus.in_rob_mispredict) begin
      m_pc = bus.in_rob_new_PC & ~64'd3;
      m_epoch = (m_epoch + 1) % (1 << EW);
      m_sq_left = SQ; m_boot = 0; m_halted = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_sq_left > 0) begin
      m_sq_left--;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (bus.in_d_stall) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (bus.in_f_is_halt) begin
      m_halted = 1;
    end else if (bus.in_f_is_uncond) begin
      m_pc = m_pc + bus.in_f_imm;
    end else if (bus.in_f_is_bcond) begin
      m_bpc = m_pc + bus.in_f_imm;
      m_pc = m_pc + 64'd4;
    end else begin
      m_pc = m_pc + 64'd4;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_addr", bus.out_imem_addr, m_pc);
      chk("m_valid", 64'(bus.out_f_valid), 64'(m_valid()));
      chk("m_squash", 64'(bus.out_squash), 64'(m_sq_left > 0));
      chk("m_epoch", 64'(bus.out_epoch), 64'(m_epoch));
      chk("m_bpc", bus.out_branch_PC, m_bpc);
      chk("m_cnt", 64'(bus.out_stall_cnt), 64'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_rob_mispredict = 0;
    bus.in_d_stall = 0;
    bus.in_f_is_bcond = 0;
    bus.in_f_is_uncond = 0;
    bus.in_f_is_halt = 0;
    bus.in_f_imm = 0;
  endtask

  task automatic redirect(logic [63:0] t);
    bus.in_rob_mispredict = 1;
    bus.in_rob_new_PC = t;
    cyc();
    bus.in_rob_mispredict = 0;
    repeat (SQ) cyc();
  endtask

  initial begin
    bus.in_entry_pc = 64'h1000;
    bus.in_rob_new_PC = 0;
    idle();
    rst = 1;
    cyc();
    chk_en = 1;
    rst = 0;
    // T1
    chk("t1_addr", bus.out_imem_addr, 64'h1000);
    chk("t1_squash", 64'(bus.out_squash), 0);
    chk("t1_epoch", 64'(bus.out_epoch), 0);
    chk("t1_bpc", bus.out_branch_PC, 0);
    chk("t1_cnt", 64'(bus.out_stall_cnt), 0);
    chk("t1_boot_v", 64'(bus.out_f_valid), 0);
    cyc();
    chk("t1_a0", bus.out_imem_addr, 64'h1000);
    chk("t1_v0", 64'(bus.out_f_valid), 1);
    cyc();
    chk("t1_a1", bus.out_imem_addr, 64'h1004);
    cyc();
    chk("t1_a2", bus.out_imem_addr, 64'h1008);
    // T2
    redirect(64'h2000);
    chk("t2_addr", bus.out_imem_addr, 64'h2000);
    chk("t2_epoch", 64'(bus.out_epoch), 1);
    bus.in_f_is_uncond = 1;
    bus.in_f_imm = -64'sd8;
    cyc();
    idle();
    chk("t2_uncond", bus.out_imem_addr, 64'h1FF8);
    redirect(64'h2000);
    bus.in_f_is_bcond = 1;
    bus.in_f_imm = -64'sd8;
    cyc();
    idle();
    chk("t2_bc_addr", bus.out_imem_addr, 64'h2004);
    chk("t2_bc_bpc", bus.out_branch_PC, 64'h1FF8);
    bus.in_f_is_uncond = 1;
    bus.in_f_is_bcond = 1;
    bus.in_f_imm = 64'h100;
    cyc();
    idle();
    chk("t2_prio_addr", bus.out_imem_addr, 64'h2104);
    chk("t2_prio_bpc", bus.out_branch_PC, 64'h1FF8);
    // T3
    redirect(64'h3000);
    bus.in_d_stall = 1;
    repeat (3) begin
      #1 chk("t3_v", 64'(bus.out_f_valid), 0);
      cyc();
      chk("t3_hold", bus.out_imem_addr, 64'h3000);
    end
    chk("t3_cnt", 64'(bus.out_stall_cnt), 3);
    bus.in_d_stall = 0;
    cyc();
    chk("t3_resume", bus.out_imem_addr, 64'h3004);
    // T4
    bus.in_rob_mispredict = 1;
    bus.in_rob_new_PC = 64'h4002;
    bus.in_d_stall = 1;
    #1 chk("t4_v", 64'(bus.out_f_valid), 0);
    cyc();
    idle();
    chk("t4_addr", bus.out_imem_addr, 64'h4000);
    chk("t4_sq1", 64'(bus.out_squash), 1);
    chk("t4_epoch", 64'(bus.out_epoch), 4);
    cyc();
    chk("t4_sq2", 64'(bus.out_squash), 1);
    cyc();
    chk("t4_sq_end", 64'(bus.out_squash), 0);
    chk("t4_run_v", 64'(bus.out_f_valid), 1);
    chk("t4_cnt", 64'(bus.out_stall_cnt), 3);
    // T5
    redirect(64'h5000);
    bus.in_f_is_halt = 1;
    #1 chk("t5_hv", 64'(bus.out_f_valid), 1);
    cyc();
    idle();
    repeat (12) cyc();
    chk("t5_hold", bus.out_imem_addr, 64'h5000);
    chk("t5_hv0", 64'(bus.out_f_valid), 0);
    redirect(64'h6000);
    chk("t5_exit", bus.out_imem_addr, 64'h6000);
    chk("t5_ev", 64'(bus.out_f_valid), 1);
    bus.in_f_is_halt = 1;
    bus.in_f_is_uncond = 1;
    bus.in_f_imm = 64'h40;
    cyc();
    idle();
    cyc();
    chk("t5_hprio", bus.out_imem_addr, 64'h6000);
    // PC wrap
    redirect(64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_tgt", bus.out_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    chk("wrap_pc", bus.out_imem_addr, 64'h0);
    // T6
    bus.in_rob_mispredict = 1;
    bus.in_rob_new_PC = 64'h7000;
    cyc();
    idle();
    chk("t6_sq", 64'(bus.out_squash), 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_addr", bus.out_imem_addr, 64'h1000);
    chk("t6_squash", 64'(bus.out_squash), 0);
    chk("t6_epoch", 64'(bus.out_epoch), 0);
    chk("t6_bpc", bus.out_branch_PC, 0);
    chk("t6_cnt", 64'(bus.out_stall_cnt), 0);
    cyc();
    for (int i = 0; i < 9; i++) begin
      bus.in_rob_mispredict = 1;
      bus.in_rob_new_PC = 64'h8000 + 64'(16 * i);
      cyc();
    end
    idle();
    chk("t6_wrap", 64'(bus.out_epoch), 1);
    chk("t6_last", bus.out_imem_addr, 64'h8080);
    cyc();
    chk("t6_restart", 64'(bus.out_squash), 1);
    cyc();
    chk("t6_done", 64'(bus.out_squash), 0);
    // Stall counter saturation
    bus.in_d_stall = 1;
    repeat (65540) cyc();
    chk("sat_cnt", 64'(bus.out_stall_cnt), 64'hFFFF);
    chk("sat_addr", bus.out_imem_addr, 64'h8080);
    idle();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
